// File: rtl/harmonic_lock_tracker_pkg.sv
// Shared Q14 constants, encodings and default thresholds for the harmonic lock tracker.
package harmonic_lock_tracker_pkg;

    localparam int unsigned HSI_WIDTH = 18;
    localparam int unsigned HSI_FRAC  = 14;
    localparam int unsigned Q14_ONE   = 16384;
    localparam int unsigned Q14_HALF  = 8192;

    localparam int          DEF_ENTER_TH  = 13107;
    localparam int          DEF_EXIT_TH   = 11469;
    localparam int          DEF_TREND_TH  = 164;
    localparam int unsigned DEF_ACQ_DWELL = 16;
    localparam int unsigned DEF_REL_DWELL = 64;
    localparam int unsigned DEF_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_RELEASE = 2'd3
    } lock_state_e;

    typedef enum logic [1:0] {
        TR_STEADY  = 2'd0,
        TR_TIGHTEN = 2'd1,
        TR_LOOSEN  = 2'd2
    } trend_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/harmonic_lock_tracker_sat_counter.sv
// Saturating up-counter with synchronous clear and load; clear wins over load, load over inc.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/harmonic_lock_tracker.sv
// Debounces per-tick harmonic lock samples into lock episodes with hysteresis,
// episode statistics, peak HSI and a delta-HSI trend flag.
module harmonic_lock_tracker
    import harmonic_lock_tracker_pkg::*;
#(
    parameter int unsigned WIDTH     = HSI_WIDTH,
    parameter int unsigned FRAC      = HSI_FRAC,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int          ENTER_TH  = DEF_ENTER_TH,
    parameter int          EXIT_TH   = DEF_EXIT_TH,
    parameter int unsigned ACQ_DWELL = DEF_ACQ_DWELL,
    parameter int unsigned REL_DWELL = DEF_REL_DWELL,
    parameter int          TREND_TH  = DEF_TREND_TH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] hsi,
    input  logic signed [WIDTH-1:0] delta_hsi,
    input  logic                    harmonic_locked,
    output logic [1:0]              lock_state,
    output logic                    lock_stable,
    output logic                    lock_onset,
    output logic                    lock_release,
    output logic [CNT_W-1:0]        episode_len,
    output logic [CNT_W-1:0]        last_episode_len,
    output logic [CNT_W-1:0]        episode_count,
    output logic signed [WIDTH-1:0] peak_hsi,
    output logic [1:0]              trend
);

    localparam int unsigned DW = $clog2(max_u(ACQ_DWELL, REL_DWELL)) + 1;

    localparam logic signed [WIDTH-1:0] ENTER_S   = WIDTH'(ENTER_TH);
    localparam logic signed [WIDTH-1:0] EXIT_S    = WIDTH'(EXIT_TH);
    localparam logic signed [WIDTH-1:0] TREND_POS = WIDTH'(TREND_TH);
    localparam logic signed [WIDTH-1:0] TREND_NEG = WIDTH'(-TREND_TH);
    localparam logic signed [WIDTH-1:0] BAND_POS  = WIDTH'(TREND_TH >>> 1);
    localparam logic signed [WIDTH-1:0] BAND_NEG  = WIDTH'(-(TREND_TH >>> 1));

    if ((EXIT_TH >= ENTER_TH) || (ACQ_DWELL < 2) || (REL_DWELL < 2) || (FRAC >= WIDTH)) begin : g_param_check
        $error("harmonic_lock_tracker: inconsistent threshold/dwell/format parameters");
    end

    lock_state_e       state, state_next;
    trend_e            trend_r, trend_next;
    logic [DW-1:0]     dwell;
    logic              dwell_inc, dwell_clr, dwell_load;
    logic              len_inc, len_clr, cnt_inc;
    logic              onset_c, release_c, load_peak, track_peak;
    logic              enter_q, hold_q, in_band;
    logic [CNT_W-1:0]  len_plus1;

    // Negative hsi naturally fails both positive thresholds under signed compare.
    assign enter_q   = harmonic_locked && (hsi >= ENTER_S);
    assign hold_q    = harmonic_locked && (hsi >= EXIT_S);
    assign in_band   = (delta_hsi > BAND_NEG) && (delta_hsi < BAND_POS);
    assign len_plus1 = (episode_len == {CNT_W{1'b1}}) ? episode_len : episode_len + CNT_W'(1);

    assign lock_state = state;
    assign trend      = trend_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (clk_en) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dwell_inc  = 1'b0;
        dwell_clr  = 1'b0;
        dwell_load = 1'b0;
        len_inc    = 1'b0;
        len_clr    = 1'b0;
        cnt_inc    = 1'b0;
        onset_c    = 1'b0;
        release_c  = 1'b0;
        load_peak  = 1'b0;
        track_peak = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enter_q) begin
                    state_next = ST_ACQUIRE;
                    dwell_load = 1'b1;
                end
            end
            ST_ACQUIRE: begin
                if (!enter_q) begin
                    state_next = ST_IDLE;
                    dwell_clr  = 1'b1;
                end else if (dwell == DW'(ACQ_DWELL - 1)) begin
                    state_next = ST_LOCKED;
                    onset_c    = 1'b1;
                    len_clr    = 1'b1;
                    load_peak  = 1'b1;
                    dwell_clr  = 1'b1;
                end else begin
                    dwell_inc = 1'b1;
                end
            end
            ST_LOCKED: begin
                len_inc    = 1'b1;
                track_peak = 1'b1;
                if (!hold_q) begin
                    state_next = ST_RELEASE;
                    dwell_load = 1'b1;
                end
            end
            ST_RELEASE: begin
                track_peak = 1'b1;
                if (hold_q) begin
                    state_next = ST_LOCKED;
                    dwell_clr  = 1'b1;
                    len_inc    = 1'b1;
                end else if (dwell == DW'(REL_DWELL - 1)) begin
                    state_next = ST_IDLE;
                    release_c  = 1'b1;
                    len_clr    = 1'b1;
                    cnt_inc    = 1'b1;
                    dwell_clr  = 1'b1;
                end else begin
                    len_inc   = 1'b1;
                    dwell_inc = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Trend hysteresis: opposite threshold flips directly, the inner band returns to steady.
    always_comb begin
        trend_next = trend_r;
        case (trend_r)
            TR_STEADY: begin
                if (delta_hsi > TREND_POS)      trend_next = TR_TIGHTEN;
                else if (delta_hsi < TREND_NEG) trend_next = TR_LOOSEN;
            end
            TR_TIGHTEN: begin
                if (delta_hsi < TREND_NEG) trend_next = TR_LOOSEN;
                else if (in_band)          trend_next = TR_STEADY;
            end
            TR_LOOSEN: begin
                if (delta_hsi > TREND_POS) trend_next = TR_TIGHTEN;
                else if (in_band)          trend_next = TR_STEADY;
            end
            default: trend_next = TR_STEADY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_onset       <= 1'b0;
            lock_release     <= 1'b0;
            lock_stable      <= 1'b0;
            last_episode_len <= '0;
            peak_hsi         <= '0;
            trend_r          <= TR_STEADY;
        end else begin
            lock_onset   <= clk_en && onset_c;
            lock_release <= clk_en && release_c;
            if (clk_en) begin
                lock_stable <= (state_next == ST_LOCKED) || (state_next == ST_RELEASE);
                trend_r     <= trend_next;
                if (release_c) begin
                    last_episode_len <= len_plus1;
                end
                if (load_peak) begin
                    peak_hsi <= hsi;
                end else if (track_peak && (hsi > peak_hsi)) begin
                    peak_hsi <= hsi;
                end
            end
        end
    end

    sat_counter #(.W(DW)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .inc  (clk_en && dwell_inc),
        .clr  (clk_en && dwell_clr),
        .load (clk_en && dwell_load),
        .d    (DW'(1)),
        .q    (dwell)
    );

    sat_counter #(.W(CNT_W)) u_episode_len (
        .clk  (clk),
        .rst  (rst),
        .inc  (clk_en && len_inc),
        .clr  (clk_en && len_clr),
        .load (1'b0),
        .d    ('0),
        .q    (episode_len)
    );

    sat_counter #(.W(CNT_W)) u_episode_count (
        .clk  (clk),
        .rst  (rst),
        .inc  (clk_en && cnt_inc),
        .clr  (1'b0),
        .load (1'b0),
        .d    ('0),
        .q    (episode_count)
    );

endmodule
